button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Parametrised multi-channel successor to the per-button push-button delay instances in the pong top level.
- Each channel synchronises a raw board button, debounces it, and emits a clean level, one-cycle press and release pulses, and a "step" pulse with optional hold-to-repeat, so the image generator can move a paddle continuously while a button is held.
- A single instance replaces the four separate instances for up_L, down_L, up_R and down_R, and runs on the pixel clock.

Parameters:
- N_CH, 4: number of independent button channels.
- SYNC_STAGES, 2: synchroniser flip-flop depth, minimum 2.
- DEBOUNCE_CYCLES, 250000: consecutive disagreeing samples required to accept a new level (10 ms at 25 MHz), minimum 1.
- REPEAT_DELAY, 12500000: cycles from press to first auto-repeat step (500 ms), minimum 1.
- REPEAT_RATE, 2500000: cycles between subsequent auto-repeat steps (100 ms), minimum 1.
- Counter widths are localparams derived with $clog2 of the largest count; they are not user parameters.

Ports:
- pixel_clk  input  1  single clock for all logic.
- reset  input  1  asynchronous, active-high reset.
- btn_in  input  N_CH  raw buttons, active-high, asynchronous to pixel_clk.
- repeat_en  input  N_CH  per-channel auto-repeat enable, synchronous, sampled every cycle.
- btn_level  output  N_CH  debounced button state.
- btn_press  output  N_CH  one-cycle pulse when btn_level rises.
- btn_release  output  N_CH  one-cycle pulse when btn_level falls.
- btn_step  output  N_CH  one-cycle pulse on press, then on each auto-repeat.

Behaviour:
- Reset (asynchronous): synchroniser flops, stable state, counters and FSMs all clear. All outputs are 0 and every FSM is in IDLE. Outputs are 0 during reset and in the first cycle after it.
- All outputs are registered. Channels are fully independent; there is no cross-channel interaction.
- Synchroniser: btn_in[i] passes through SYNC_STAGES flops, giving sync[i].
- Debounce:
  - Per-channel counter db_cnt.
  - If sync differs from stable, db_cnt increments.
  - When db_cnt reaches DEBOUNCE_CYCLES-1 while sync still differs, stable toggles on the next edge and db_cnt clears.
  - If sync equals stable, db_cnt clears that cycle. Any glitch shorter than DEBOUNCE_CYCLES is therefore ignored.
  - Latency from the btn_in edge to the btn_level edge is SYNC_STAGES+DEBOUNCE_CYCLES cycles, ±1 for asynchronous sampling.
- btn_level equals stable.
- btn_press and btn_release assert in the same cycle that btn_level changes, for exactly 1 cycle.
- Repeat FSM per channel, with states IDLE, HOLD_DELAY and REPEATING, and timer rp_cnt:
  - IDLE: on a press, btn_step=1 in the same cycle as btn_press. If repeat_en=1, go to HOLD_DELAY with rp_cnt=0; otherwise stay in IDLE.
  - HOLD_DELAY: rp_cnt increments each cycle. When rp_cnt=REPEAT_DELAY-1, btn_step=1, rp_cnt clears and the FSM goes to REPEATING. The first repeat step therefore occurs exactly REPEAT_DELAY cycles after the press cycle.
  - REPEATING: rp_cnt increments each cycle. When rp_cnt=REPEAT_RATE-1, btn_step=1 and rp_cnt clears. Steps occur at press+REPEAT_DELAY+k*REPEAT_RATE.
  - Release while in any state: go to IDLE and clear rp_cnt. btn_step=0 on the release cycle, even if the timer would have expired in that same cycle (release wins).
  - repeat_en low while in HOLD_DELAY or REPEATING: go to IDLE and clear rp_cnt on the next edge, with no step in that cycle. Re-asserting repeat_en while the button is still held does not restart repeating; a new press is required.
- Only btn_in is asynchronous; repeat_en is assumed synchronous.
- No step is ever generated while btn_level=0.
- Counters never wrap: every count is bounded by an explicit compare-and-clear.

Test Plan:
All scenarios use N_CH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
1. Assert reset mid-activity with btn_in=4'hF held -> all outputs become 0 immediately. After release of reset with btn_in still 4'hF, btn_level=4'hF appears 6±1 cycles later, with btn_press=4'hF for 1 cycle.
2. Ch0 glitches of 1, 2 and 3 cycles separated by 5 low cycles -> btn_level[0], btn_press[0] and btn_step[0] stay 0 throughout.
3. Ch1 held 40 cycles with repeat_en[1]=1 -> btn_step[1] pulses at press cycle T and at T+10, T+13, T+16, ... up to release. On release: btn_release[1] for 1 cycle and no further steps.
4. Ch2 held 40 cycles with repeat_en[2]=0 -> exactly one btn_step[2], coincident with btn_press[2].
5. Ch3 repeating, with release debounced on the cycle where rp_cnt=REPEAT_RATE-1 -> btn_step[3]=0 that cycle. Separately, dropping repeat_en[3] at T+11 -> no step at T+13 or later.
6. Ch0 and Ch1 pressed 2 cycles apart, both with repeat enabled -> independent step trains offset by 2 cycles, with no interference and no missed or duplicated pulses.

Source files
------------

// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner for the pixel-clock domain.
// Each channel synchronises a raw button, debounces it and produces a clean
// level, one-cycle press/release pulses and a step pulse with hold-to-repeat.
//
// Ports:
//   pixel_clk   - single clock for all logic
//   reset       - asynchronous, active-high reset
//   btn_in      - raw active-high buttons, asynchronous to pixel_clk
//   repeat_en   - per-channel auto-repeat enable (synchronous)
//   btn_level   - debounced button state
//   btn_press   - one-cycle pulse when btn_level rises
//   btn_release - one-cycle pulse when btn_level falls
//   btn_step    - one-cycle pulse on press, then on each auto-repeat
module button_conditioner #(
    parameter int unsigned N_CH            = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_DELAY    = 12500000,
    parameter int unsigned REPEAT_RATE     = 2500000
) (
    input  logic            pixel_clk,
    input  logic            reset,
    input  logic [N_CH-1:0] btn_in,
    input  logic [N_CH-1:0] repeat_en,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] btn_step
);

    // Counters only ever hold values up to (count - 1).
    localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RP_W   = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;

    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] RATE_LAST  = RP_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD_DELAY,
        REPEATING
    } rep_state_t;

    for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sync;
        logic                   stable_q;
        logic [DB_W-1:0]        db_cnt;
        logic                   db_done;
        logic                   press_q;
        logic                   release_q;
        logic                   step_q;
        rep_state_t             state_q;
        logic [RP_W-1:0]        rp_cnt;

        assign sync    = sync_q[SYNC_STAGES-1];
        // Stable level flips on the next edge when this is high.
        assign db_done = (sync != stable_q) && (db_cnt == DB_LAST);

        // Metastability synchroniser.
        always_ff @(posedge pixel_clk or posedge reset) begin
            if (reset) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in[i]};
            end
        end

        // Debounce: accept a new level only after DEBOUNCE_CYCLES disagreeing samples.
        always_ff @(posedge pixel_clk or posedge reset) begin
            if (reset) begin
                stable_q <= 1'b0;
                db_cnt   <= '0;
            end else if (sync != stable_q) begin
                if (db_cnt == DB_LAST) begin
                    stable_q <= ~stable_q;
                    db_cnt   <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end

        // Edge pulses registered alongside the level change.
        always_ff @(posedge pixel_clk or posedge reset) begin
            if (reset) begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= db_done & ~stable_q;
                release_q <= db_done &  stable_q;
            end
        end

        // Repeat FSM: release beats repeat_en drop, which beats timer expiry.
        always_ff @(posedge pixel_clk or posedge reset) begin
            if (reset) begin
                state_q <= IDLE;
                rp_cnt  <= '0;
                step_q  <= 1'b0;
            end else begin
                step_q <= 1'b0;
                if (db_done && !stable_q) begin
                    step_q  <= 1'b1;
                    rp_cnt  <= '0;
                    state_q <= repeat_en[i] ? HOLD_DELAY : IDLE;
                end else if (db_done && stable_q) begin
                    state_q <= IDLE;
                    rp_cnt  <= '0;
                end else begin
                    case (state_q)
                        IDLE: begin
                            rp_cnt <= '0;
                        end
                        HOLD_DELAY: begin
                            if (!repeat_en[i]) begin
                                state_q <= IDLE;
                                rp_cnt  <= '0;
                            end else if (rp_cnt == DELAY_LAST) begin
                                step_q  <= 1'b1;
                                rp_cnt  <= '0;
                                state_q <= REPEATING;
                            end else begin
                                rp_cnt <= rp_cnt + RP_W'(1);
                            end
                        end
                        REPEATING: begin
                            if (!repeat_en[i]) begin
                                state_q <= IDLE;
                                rp_cnt  <= '0;
                            end else if (rp_cnt == RATE_LAST) begin
                                step_q <= 1'b1;
                                rp_cnt <= '0;
                            end else begin
                                rp_cnt <= rp_cnt + RP_W'(1);
                            end
                        end
                        default: begin
                            state_q <= IDLE;
                            rp_cnt  <= '0;
                        end
                    endcase
                end
            end
        end

        assign btn_level[i]   = stable_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
        assign btn_step[i]    = step_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with a cycle-level reference model
// built from the debounce/repeat timing rules (press-time arithmetic for steps).
module tb_button_conditioner;

    localparam int N  = 4;
    localparam int S  = 2;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RR = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] btn_in;
    logic [N-1:0] repeat_en;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_step;

    button_conditioner #(
        .N_CH            (N),
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR)
    ) dut (
        .pixel_clk   (clk),
        .reset       (reset),
        .btn_in      (btn_in),
        .repeat_en   (repeat_en),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_step    (btn_step)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference model state
    int           t;
    logic [7:0]   hist [N];
    int           run_len [N];
    bit           lvl [N];
    bit           rep_on [N];
    int           press_t [N];
    logic [N-1:0] e_level, e_press, e_release, e_step;

    // Observed activity counters, cleared per scenario
    int n_level [N];
    int n_press [N];
    int n_rel [N];
    int n_step [N];
    int first_step [N];

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            hist[c]    = '0;
            run_len[c] = 0;
            lvl[c]     = 1'b0;
            rep_on[c]  = 1'b0;
            press_t[c] = 0;
        end
        e_level = '0; e_press = '0; e_release = '0; e_step = '0;
    endtask

    // Advances the model by one clock edge using the inputs the DUT just sampled.
    task automatic model_update();
        bit s, rise, fall, step;
        int d;
        t++;
        for (int c = 0; c < N; c++) begin
            s = hist[c][S-1];
            hist[c] = {hist[c][6:0], btn_in[c]};
            rise = 1'b0;
            fall = 1'b0;
            step = 1'b0;
            if (s != lvl[c]) begin
                run_len[c]++;
                if (run_len[c] == DB) begin
                    lvl[c]     = !lvl[c];
                    run_len[c] = 0;
                    rise       = lvl[c];
                    fall       = !lvl[c];
                end
            end else begin
                run_len[c] = 0;
            end
            if (rise) begin
                step       = 1'b1;
                press_t[c] = t;
                rep_on[c]  = repeat_en[c];
            end else if (fall) begin
                rep_on[c] = 1'b0;
            end else if (rep_on[c] && !repeat_en[c]) begin
                rep_on[c] = 1'b0;
            end else if (rep_on[c]) begin
                d = t - press_t[c];
                if (d >= RD && ((d - RD) % RR) == 0) step = 1'b1;
            end
            e_level[c]   = lvl[c];
            e_press[c]   = rise;
            e_release[c] = fall;
            e_step[c]    = step;
        end
    endtask

    task automatic clear_counts();
        for (int c = 0; c < N; c++) begin
            n_level[c] = 0; n_press[c] = 0; n_rel[c] = 0; n_step[c] = 0;
            first_step[c] = -1;
        end
    endtask

    // One clock: model on the rising edge, compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check("level",   32'(btn_level),   32'(e_level));
        check("press",   32'(btn_press),   32'(e_press));
        check("release", 32'(btn_release), 32'(e_release));
        check("step",    32'(btn_step),    32'(e_step));
        for (int c = 0; c < N; c++) begin
            n_level[c] += int'(btn_level[c]);
            n_press[c] += int'(btn_press[c]);
            n_rel[c]   += int'(btn_release[c]);
            n_step[c]  += int'(btn_step[c]);
            if (btn_step[c] && first_step[c] < 0) first_step[c] = t;
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        int lat;
        t         = 0;
        reset     = 1'b1;
        btn_in    = '0;
        repeat_en = '0;
        model_reset();
        clear_counts();
        repeat (2) @(negedge clk);
        check("por_level", 32'(btn_level), 32'h0);
        check("por_step",  32'(btn_step),  32'h0);
        reset = 1'b0;
        run(5);

        // 1: reset mid-activity with all buttons held
        repeat_en = '1;
        btn_in    = '1;
        run(15);
        reset = 1'b1;
        #1;
        model_reset();
        check("t1_rst_level",   32'(btn_level),   32'h0);
        check("t1_rst_press",   32'(btn_press),   32'h0);
        check("t1_rst_release", 32'(btn_release), 32'h0);
        check("t1_rst_step",    32'(btn_step),    32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_counts();
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (lat < 0 && btn_level == 4'hF) lat = k;
        end
        check("t1_latency", 32'(lat), 32'd6);
        for (int c = 0; c < N; c++) check("t1_press_cnt", 32'(n_press[c]), 32'd1);
        repeat_en = '0;
        btn_in    = '0;
        run(15);

        // 2: short glitches on ch0 are rejected
        clear_counts();
        for (int g = 1; g <= 3; g++) begin
            btn_in[0] = 1'b1;
            run(g);
            btn_in[0] = 1'b0;
            run(5);
        end
        check("t2_level", 32'(n_level[0]), 32'd0);
        check("t2_press", 32'(n_press[0]), 32'd0);
        check("t2_step",  32'(n_step[0]),  32'd0);

        // 3: ch1 held 40 cycles with repeat
        clear_counts();
        repeat_en = 4'b0010;
        btn_in[1] = 1'b1;
        run(40);
        btn_in[1] = 1'b0;
        run(15);
        check("t3_steps",   32'(n_step[1]),  32'd11);
        check("t3_press",   32'(n_press[1]), 32'd1);
        check("t3_release", 32'(n_rel[1]),   32'd1);

        // 4: ch2 held 40 cycles without repeat
        clear_counts();
        repeat_en = '0;
        btn_in[2] = 1'b1;
        run(40);
        btn_in[2] = 1'b0;
        run(15);
        check("t4_steps", 32'(n_step[2]),  32'd1);
        check("t4_press", 32'(n_press[2]), 32'd1);

        // 5a: release lands on a repeat-timer expiry
        clear_counts();
        repeat_en = 4'b1000;
        btn_in[3] = 1'b1;
        run(13);
        btn_in[3] = 1'b0;
        run(15);
        check("t5a_steps", 32'(n_step[3]), 32'd2);

        // 5b: repeat_en dropped at T+11, then re-asserted while held
        clear_counts();
        btn_in[3] = 1'b1;
        run(6);
        check("t5b_press", 32'(n_press[3]), 32'd1);
        run(11);
        repeat_en[3] = 1'b0;
        run(5);
        repeat_en[3] = 1'b1;
        run(24);
        btn_in[3] = 1'b0;
        run(15);
        check("t5b_steps", 32'(n_step[3]), 32'd2);

        // 6: ch0 and ch1 offset by 2 cycles, both repeating
        clear_counts();
        repeat_en = 4'b0011;
        btn_in[0] = 1'b1;
        run(2);
        btn_in[1] = 1'b1;
        run(28);
        btn_in[0] = 1'b0;
        run(2);
        btn_in[1] = 1'b0;
        run(15);
        check("t6_steps0", 32'(n_step[0]), 32'd8);
        check("t6_steps1", 32'(n_step[1]), 32'd8);
        check("t6_offset", 32'(first_step[1] - first_step[0]), 32'd2);

        // Random activity against the model
        repeat_en = 4'(($urandom));
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(7, 0) == 0) btn_in[$urandom_range(N - 1, 0)] ^= 1'b1;
            if ($urandom_range(49, 0) == 0) repeat_en[$urandom_range(N - 1, 0)] ^= 1'b1;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
